amba_ahb_m2s3_bus: RTL and testbench

//  AMBA AHB (2.0) interconnect for 2 masters and 3 slaves: arbiter, address decoder, default slave,

---
 rtl/amba_ahb_m2s3_bus.sv | 237 +++++++++++++++++++++++
 tb/tb_amba_ahb_m2s3_bus.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_m2s3_bus.sv
// rtl/amba_ahb_m2s3_bus.sv - AHB 2.0 interconnect: 2 masters, 3 slaves, arbiter, decoder, default slave
//
// Purpose:
//   Arbitrates two AHB masters onto a shared address/data bus, decodes the
//   address-phase address to one of three slave windows (or a built-in default
//   slave), and returns the data-phase slave's read data/response to the masters.
//   The arbiter also honours HLOCK, unfinished bursts and SPLIT masking.
//
// Ports:
//   HCLK, HRESETn                   clock; synchronous reset (HRESETn=1 resets)
//   Mx_HBUSREQ / Mx_HGRANT          master x request / grant (x = 0,1)
//   Mx_HADDR..Mx_HWRITE, Mx_HWDATA  master x address-phase control and write data
//   M_HRDATA, M_HRESP, M_HREADY     data-phase slave outputs broadcast to masters
//   S_HADDR..S_HPROT, S_HWDATA      muxed control / write data to the slaves
//   S_HREADY                        copy of M_HREADY for the slaves
//   S_HMASTER, S_HMASTLOCK          address-phase master index and lock
//   Sy_HSEL                         slave y select (y = 0..2)
//   Sy_HREADY, Sy_HRESP, Sy_HRDATA  slave y data-phase outputs
//   Sy_HSPLIT                       slave y un-split request (bit k = master k)
//   REMAP                           1 swaps the S0 and S1 decode windows

module amba_ahb_m2s3_bus #(
  parameter int          P_NUMM        = 2,
  parameter int          P_NUMS        = 3,
  parameter logic [31:0] P_HSEL0_START = 32'h0000_0000,
  parameter logic [31:0] P_HSEL0_SIZE  = 32'h0000_0400,
  parameter logic [31:0] P_HSEL1_START = 32'h0000_0400,
  parameter logic [31:0] P_HSEL1_SIZE  = 32'h0000_0400,
  parameter logic [31:0] P_HSEL2_START = 32'h0000_0800,
  parameter logic [31:0] P_HSEL2_SIZE  = 32'h0000_0400
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // master 0
  input  logic        M0_HBUSREQ,
  output logic        M0_HGRANT,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HLOCK,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  // master 1
  input  logic        M1_HBUSREQ,
  output logic        M1_HGRANT,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HLOCK,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  // shared master-side returns
  output logic [31:0] M_HRDATA,
  output logic [1:0]  M_HRESP,
  output logic        M_HREADY,
  // shared slave-side bus
  output logic [31:0] S_HADDR,
  output logic        S_HWRITE,
  output logic [1:0]  S_HTRANS,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  output logic [3:0]  S_HMASTER,
  output logic        S_HMASTLOCK,
  // slave 0
  output logic        S0_HSEL,
  input  logic        S0_HREADY,
  input  logic [1:0]  S0_HRESP,
  input  logic [31:0] S0_HRDATA,
  input  logic [15:0] S0_HSPLIT,
  // slave 1
  output logic        S1_HSEL,
  input  logic        S1_HREADY,
  input  logic [1:0]  S1_HRESP,
  input  logic [31:0] S1_HRDATA,
  input  logic [15:0] S1_HSPLIT,
  // slave 2
  output logic        S2_HSEL,
  input  logic        S2_HREADY,
  input  logic [1:0]  S2_HRESP,
  input  logic [31:0] S2_HRDATA,
  input  logic [15:0] S2_HSPLIT,
  input  logic        REMAP
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_SPLIT = 2'b11;
  localparam logic [1:0] SLV_DEF    = 2'd3;

  // Default slave: OKAY when idle, otherwise a two-cycle ERROR (wait, then done)
  typedef enum logic [1:0] {
    DEF_OKAY = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

  def_state_t          def_state;
  logic                grant_idx;    // currently granted master
  logic                hmaster_idx;  // address-phase master
  logic                hmastlock_q;
  logic                dp_master;    // data-phase master
  logic [1:0]          dp_slave;     // data-phase slave, SLV_DEF = default slave
  logic [P_NUMM-1:0]   split_mask;

  logic                am_hlock;
  logic                arb_hold;
  logic [P_NUMM-1:0]   m_ok;
  logic                arb_next;
  logic [2:0]          hit;
  logic [2:0]          hsel;
  logic [1:0]          target;
  logic [P_NUMM-1:0]   split_set;
  logic [P_NUMM-1:0]   split_clr;
  logic [31:0]         win0_start, win0_size, win1_start, win1_size;
  logic                unused_hsplit;

  // 33-bit arithmetic so a window ending at 4 GiB cannot wrap
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                  input logic [31:0] size);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  // Address-phase mux, selected by the registered address-phase master
  assign S_HADDR     = hmaster_idx ? M1_HADDR  : M0_HADDR;
  assign S_HWRITE    = hmaster_idx ? M1_HWRITE : M0_HWRITE;
  assign S_HTRANS    = hmaster_idx ? M1_HTRANS : M0_HTRANS;
  assign S_HSIZE     = hmaster_idx ? M1_HSIZE  : M0_HSIZE;
  assign S_HBURST    = hmaster_idx ? M1_HBURST : M0_HBURST;
  assign S_HPROT     = hmaster_idx ? M1_HPROT  : M0_HPROT;
  assign am_hlock    = hmaster_idx ? M1_HLOCK  : M0_HLOCK;
  assign S_HMASTER   = {3'b000, hmaster_idx};
  assign S_HMASTLOCK = hmastlock_q;

  // Write data follows the master that owns the data phase
  assign S_HWDATA    = dp_master ? M1_HWDATA : M0_HWDATA;

  assign M0_HGRANT   = ~grant_idx;
  assign M1_HGRANT   = grant_idx;

  // Decoder; REMAP exchanges the S0 and S1 windows
  assign win0_start = REMAP ? P_HSEL1_START : P_HSEL0_START;
  assign win0_size  = REMAP ? P_HSEL1_SIZE  : P_HSEL0_SIZE;
  assign win1_start = REMAP ? P_HSEL0_START : P_HSEL1_START;
  assign win1_size  = REMAP ? P_HSEL0_SIZE  : P_HSEL1_SIZE;

  assign hit[0] = (P_NUMS > 0) && in_win(S_HADDR, win0_start, win0_size);
  assign hit[1] = (P_NUMS > 1) && in_win(S_HADDR, win1_start, win1_size);
  assign hit[2] = (P_NUMS > 2) && in_win(S_HADDR, P_HSEL2_START, P_HSEL2_SIZE);

  // Priority keeps the selects one-hot even if windows were set to overlap
  assign hsel[0] = hit[0];
  assign hsel[1] = hit[1] & ~hit[0];
  assign hsel[2] = hit[2] & ~hit[1] & ~hit[0];
  assign S0_HSEL = hsel[0];
  assign S1_HSEL = hsel[1];
  assign S2_HSEL = hsel[2];

  always_comb begin
    target = SLV_DEF;
    if (hsel[0])      target = 2'd0;
    else if (hsel[1]) target = 2'd1;
    else if (hsel[2]) target = 2'd2;
  end

  // Data-phase response mux
  always_comb begin
    M_HREADY = 1'b1;
    M_HRESP  = RESP_OKAY;
    M_HRDATA = 32'h0;
    case (dp_slave)
      2'd0: begin M_HREADY = S0_HREADY; M_HRESP = S0_HRESP; M_HRDATA = S0_HRDATA; end
      2'd1: begin M_HREADY = S1_HREADY; M_HRESP = S1_HRESP; M_HRDATA = S1_HRDATA; end
      2'd2: begin M_HREADY = S2_HREADY; M_HRESP = S2_HRESP; M_HRDATA = S2_HRDATA; end
      default: begin
        M_HREADY = (def_state != DEF_ERR1);
        M_HRESP  = (def_state == DEF_OKAY) ? RESP_OKAY : RESP_ERROR;
        M_HRDATA = 32'h0;
      end
    endcase
  end
  assign S_HREADY = M_HREADY;

  // Arbitration: M0 has priority; masked (split) masters are ineligible, and
  // with no eligible requester the bus parks on M0.
  assign m_ok[0]  = M0_HBUSREQ & ~split_mask[0];
  assign m_ok[1]  = M1_HBUSREQ & ~split_mask[1];
  assign arb_next = ~m_ok[0] & m_ok[1];
  // A locked transfer or a burst in progress (BUSY/SEQ both have HTRANS[0]=1) keeps the bus
  assign arb_hold = am_hlock | S_HTRANS[0];

  // SPLIT completing marks the data-phase master; any slave's HSPLIT releases it
  always_comb begin
    split_set = '0;
    if (M_HREADY && (M_HRESP == RESP_SPLIT)) split_set[dp_master] = 1'b1;
  end
  assign split_clr = ((P_NUMS > 0) ? S0_HSPLIT[P_NUMM-1:0] : '0)
                   | ((P_NUMS > 1) ? S1_HSPLIT[P_NUMM-1:0] : '0)
                   | ((P_NUMS > 2) ? S2_HSPLIT[P_NUMM-1:0] : '0);
  assign unused_hsplit = ^{S0_HSPLIT[15:P_NUMM], S1_HSPLIT[15:P_NUMM], S2_HSPLIT[15:P_NUMM]};

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      grant_idx   <= 1'b0;
      hmaster_idx <= 1'b0;
      hmastlock_q <= 1'b0;
      dp_master   <= 1'b0;
      dp_slave    <= SLV_DEF;
      split_mask  <= '0;
      def_state   <= DEF_OKAY;
    end else begin
      // set after clear so a same-cycle SPLIT wins over HSPLIT
      split_mask <= (split_mask & ~split_clr) | split_set;
      if (M_HREADY) begin
        if (!arb_hold) grant_idx <= arb_next;
        hmaster_idx <= grant_idx;
        hmastlock_q <= grant_idx ? M1_HLOCK : M0_HLOCK;
        dp_master   <= hmaster_idx;
        dp_slave    <= target;
        def_state   <= ((target == SLV_DEF) && S_HTRANS[1]) ? DEF_ERR1 : DEF_OKAY;
      end else if (def_state == DEF_ERR1) begin
        def_state <= DEF_ERR2;
      end
    end
  end

endmodule

// File: tb/tb_amba_ahb_m2s3_bus.sv
// tb/tb_amba_ahb_m2s3_bus.sv - directed self-checking bench for amba_ahb_m2s3_bus

module tb_amba_ahb_m2s3_bus;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        M0_HBUSREQ, M0_HGRANT, M0_HLOCK, M0_HWRITE;
  logic [31:0] M0_HADDR, M0_HWDATA;
  logic [1:0]  M0_HTRANS;
  logic [2:0]  M0_HSIZE, M0_HBURST;
  logic [3:0]  M0_HPROT;
  logic        M1_HBUSREQ, M1_HGRANT, M1_HLOCK, M1_HWRITE;
  logic [31:0] M1_HADDR, M1_HWDATA;
  logic [1:0]  M1_HTRANS;
  logic [2:0]  M1_HSIZE, M1_HBURST;
  logic [3:0]  M1_HPROT;
  logic [31:0] M_HRDATA;
  logic [1:0]  M_HRESP;
  logic        M_HREADY;
  logic [31:0] S_HADDR, S_HWDATA;
  logic        S_HWRITE, S_HREADY, S_HMASTLOCK;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT, S_HMASTER;
  logic        S0_HSEL, S1_HSEL, S2_HSEL;
  logic        S0_HREADY, S1_HREADY, S2_HREADY;
  logic [1:0]  S0_HRESP, S1_HRESP, S2_HRESP;
  logic [31:0] S0_HRDATA, S1_HRDATA, S2_HRDATA;
  logic [15:0] S0_HSPLIT, S1_HSPLIT, S2_HSPLIT;
  logic        REMAP;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADDR_NONE = 32'h0000_0FF0;

  always #5 HCLK = ~HCLK;

  amba_ahb_m2s3_bus dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HBUSREQ(M0_HBUSREQ), .M0_HGRANT(M0_HGRANT), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HLOCK(M0_HLOCK),
    .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA),
    .M1_HBUSREQ(M1_HBUSREQ), .M1_HGRANT(M1_HGRANT), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HLOCK(M1_HLOCK),
    .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA),
    .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP), .M_HREADY(M_HREADY),
    .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HMASTER(S_HMASTER), .S_HMASTLOCK(S_HMASTLOCK),
    .S0_HSEL(S0_HSEL), .S0_HREADY(S0_HREADY), .S0_HRESP(S0_HRESP), .S0_HRDATA(S0_HRDATA), .S0_HSPLIT(S0_HSPLIT),
    .S1_HSEL(S1_HSEL), .S1_HREADY(S1_HREADY), .S1_HRESP(S1_HRESP), .S1_HRDATA(S1_HRDATA), .S1_HSPLIT(S1_HSPLIT),
    .S2_HSEL(S2_HSEL), .S2_HREADY(S2_HREADY), .S2_HRESP(S2_HRESP), .S2_HRDATA(S2_HRDATA), .S2_HSPLIT(S2_HSPLIT),
    .REMAP(REMAP)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b1; REMAP = 1'b0;
    M0_HBUSREQ = 0; M0_HLOCK = 0; M0_HWRITE = 0; M0_HADDR = ADDR_NONE; M0_HWDATA = 0;
    M0_HTRANS = 2'b00; M0_HSIZE = 3'b010; M0_HBURST = 3'b000; M0_HPROT = 4'h3;
    M1_HBUSREQ = 0; M1_HLOCK = 0; M1_HWRITE = 0; M1_HADDR = ADDR_NONE; M1_HWDATA = 0;
    M1_HTRANS = 2'b00; M1_HSIZE = 3'b010; M1_HBURST = 3'b000; M1_HPROT = 4'h3;
    S0_HREADY = 1; S0_HRESP = 2'b00; S0_HRDATA = 32'hA0A0_0000; S0_HSPLIT = 16'h0;
    S1_HREADY = 1; S1_HRESP = 2'b00; S1_HRDATA = 32'h0000_0005; S1_HSPLIT = 16'h0;
    S2_HREADY = 1; S2_HRESP = 2'b00; S2_HRDATA = 32'hC2C2_0000; S2_HSPLIT = 16'h0;
    tick(); tick();
    HRESETn = 1'b0;
    #1;
    checks++; if (M0_HGRANT !== 1'b1) begin failures++; $display("FAIL reset_m0_grant got=%b exp=1", M0_HGRANT); end
    checks++; if (M1_HGRANT !== 1'b0) begin failures++; $display("FAIL reset_m1_grant got=%b exp=0", M1_HGRANT); end
    checks++; if (S_HMASTER !== 4'd0) begin failures++; $display("FAIL reset_hmaster got=%0d exp=0", S_HMASTER); end
    checks++; if (M_HREADY !== 1'b1) begin failures++; $display("FAIL reset_hready got=%b exp=1", M_HREADY); end
    checks++; if (S_HREADY !== 1'b1) begin failures++; $display("FAIL reset_s_hready got=%b exp=1", S_HREADY); end
    checks++; if (M_HRESP !== 2'b00) begin failures++; $display("FAIL reset_hresp got=%b exp=00", M_HRESP); end
    checks++; if (M_HRDATA !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", M_HRDATA); end
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b000) begin failures++; $display("FAIL reset_hsel got=%b exp=000", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    checks++; if (S_HMASTLOCK !== 1'b0) begin failures++; $display("FAIL reset_mastlock got=%b exp=0", S_HMASTLOCK); end
  endtask

  task automatic test_m0_write();
    M0_HBUSREQ = 1; M0_HADDR = 32'h0; M0_HTRANS = 2'b10; M0_HWRITE = 1; M0_HSIZE = 3'b000;
    #1;
    checks++; if (S_HADDR !== 32'h0) begin failures++; $display("FAIL wr_haddr got=%h exp=0", S_HADDR); end
    checks++; if (S0_HSEL !== 1'b1) begin failures++; $display("FAIL wr_s0_hsel got=%b exp=1", S0_HSEL); end
    checks++; if (S_HWRITE !== 1'b1) begin failures++; $display("FAIL wr_hwrite got=%b exp=1", S_HWRITE); end
    checks++; if (S_HTRANS !== 2'b10) begin failures++; $display("FAIL wr_htrans got=%b exp=10", S_HTRANS); end
    checks++; if (S_HSIZE !== 3'b000) begin failures++; $display("FAIL wr_hsize got=%b exp=000", S_HSIZE); end
    tick();
    M0_HTRANS = 2'b00; M0_HADDR = ADDR_NONE; M0_HWRITE = 0; M0_HWDATA = 32'd7; M0_HSIZE = 3'b010;
    #1;
    checks++; if (S_HWDATA !== 32'd7) begin failures++; $display("FAIL wr_hwdata got=%h exp=7", S_HWDATA); end
    checks++; if (M_HREADY !== 1'b1) begin failures++; $display("FAIL wr_hready got=%b exp=1", M_HREADY); end
  endtask

  task automatic test_m1_read();
    M0_HBUSREQ = 0;
    M1_HBUSREQ = 1; M1_HADDR = 32'h401; M1_HTRANS = 2'b10; M1_HWRITE = 0;
    #1;
    checks++; if (M1_HGRANT !== 1'b0) begin failures++; $display("FAIL rd_grant_early got=%b exp=0", M1_HGRANT); end
    tick();
    checks++; if (M1_HGRANT !== 1'b1) begin failures++; $display("FAIL rd_m1_grant got=%b exp=1", M1_HGRANT); end
    checks++; if (M0_HGRANT !== 1'b0) begin failures++; $display("FAIL rd_m0_grant got=%b exp=0", M0_HGRANT); end
    checks++; if (S_HMASTER !== 4'd0) begin failures++; $display("FAIL rd_hmaster_lag got=%0d exp=0", S_HMASTER); end
    tick();
    checks++; if (S_HMASTER !== 4'd1) begin failures++; $display("FAIL rd_hmaster got=%0d exp=1", S_HMASTER); end
    checks++; if (S1_HSEL !== 1'b1) begin failures++; $display("FAIL rd_s1_hsel got=%b exp=1", S1_HSEL); end
    checks++; if (S_HADDR !== 32'h401) begin failures++; $display("FAIL rd_haddr got=%h exp=401", S_HADDR); end
    tick();
    checks++; if (M_HRDATA !== 32'd5) begin failures++; $display("FAIL rd_hrdata got=%h exp=5", M_HRDATA); end
    M1_HTRANS = 2'b00; M1_HADDR = ADDR_NONE;
  endtask

  task automatic test_arbitration();
    M0_HBUSREQ = 1; M1_HBUSREQ = 1;
    tick();
    checks++; if (M0_HGRANT !== 1'b1) begin failures++; $display("FAIL arb_prio got=%b exp=1", M0_HGRANT); end
    M0_HBUSREQ = 0;
    tick();
    checks++; if (M1_HGRANT !== 1'b1) begin failures++; $display("FAIL arb_handover got=%b exp=1", M1_HGRANT); end
    M0_HBUSREQ = 1;
    tick();
    checks++; if (M0_HGRANT !== 1'b1) begin failures++; $display("FAIL arb_regrant got=%b exp=1", M0_HGRANT); end
    M0_HLOCK = 1; M0_HADDR = 32'h0; M0_HTRANS = 2'b10;
    tick();
    checks++; if (S_HMASTER !== 4'd0) begin failures++; $display("FAIL lock_hmaster got=%0d exp=0", S_HMASTER); end
    checks++; if (S_HMASTLOCK !== 1'b1) begin failures++; $display("FAIL lock_mastlock got=%b exp=1", S_HMASTLOCK); end
    M0_HBUSREQ = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (M1_HGRANT !== 1'b0) begin failures++; $display("FAIL lock_hold[%0d] got=%b exp=0", i, M1_HGRANT); end
    end
    M0_HLOCK = 0; M0_HTRANS = 2'b00; M0_HADDR = ADDR_NONE;
    tick();
    checks++; if (M1_HGRANT !== 1'b1) begin failures++; $display("FAIL lock_release got=%b exp=1", M1_HGRANT); end
  endtask

  task automatic test_default_slave();
    M1_HADDR = 32'hC00; M1_HTRANS = 2'b10;
    tick();
    checks++; if (S_HADDR !== 32'hC00) begin failures++; $display("FAIL def_haddr got=%h exp=c00", S_HADDR); end
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b000) begin failures++; $display("FAIL def_hsel got=%b exp=000", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    tick();
    M1_HTRANS = 2'b00;
    #1;
    checks++; if (M_HREADY !== 1'b0) begin failures++; $display("FAIL def_err1_hready got=%b exp=0", M_HREADY); end
    checks++; if (M_HRESP !== 2'b01) begin failures++; $display("FAIL def_err1_hresp got=%b exp=01", M_HRESP); end
    tick();
    checks++; if (M_HREADY !== 1'b1) begin failures++; $display("FAIL def_err2_hready got=%b exp=1", M_HREADY); end
    checks++; if (M_HRESP !== 2'b01) begin failures++; $display("FAIL def_err2_hresp got=%b exp=01", M_HRESP); end
    checks++; if (M_HRDATA !== 32'h0) begin failures++; $display("FAIL def_hrdata got=%h exp=0", M_HRDATA); end
    tick();
    checks++; if (M_HRESP !== 2'b00) begin failures++; $display("FAIL def_idle_hresp got=%b exp=00", M_HRESP); end
  endtask

  task automatic test_remap();
    REMAP = 1; M1_HADDR = 32'h000;
    #1;
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b010) begin failures++; $display("FAIL remap_lo got=%b exp=010", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    M1_HADDR = 32'h7FC;
    #1;
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b001) begin failures++; $display("FAIL remap_hi got=%b exp=001", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    REMAP = 0; M1_HADDR = 32'h800;
    #1;
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b100) begin failures++; $display("FAIL dec_s2 got=%b exp=100", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    M1_HADDR = 32'hBFF;
    #1;
    checks++; if ({S2_HSEL, S1_HSEL, S0_HSEL} !== 3'b100) begin failures++; $display("FAIL dec_s2_top got=%b exp=100", {S2_HSEL, S1_HSEL, S0_HSEL}); end
    M1_HADDR = ADDR_NONE;
  endtask

  task automatic test_wait_split();
    M1_HADDR = 32'h404; M1_HTRANS = 2'b10;
    tick();
    S1_HREADY = 0; M1_HADDR = 32'h408; M0_HBUSREQ = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (M_HREADY !== 1'b0) begin failures++; $display("FAIL wait_hready[%0d] got=%b exp=0", i, M_HREADY); end
      checks++; if (M1_HGRANT !== 1'b1) begin failures++; $display("FAIL wait_grant[%0d] got=%b exp=1", i, M1_HGRANT); end
      checks++; if (S_HMASTER !== 4'd1) begin failures++; $display("FAIL wait_hmaster[%0d] got=%0d exp=1", i, S_HMASTER); end
      checks++; if (S_HADDR !== 32'h408) begin failures++; $display("FAIL wait_haddr[%0d] got=%h exp=408", i, S_HADDR); end
      if (i < 2) tick();
    end
    M0_HBUSREQ = 0; S1_HREADY = 1; S1_HRESP = 2'b11;
    #1;
    checks++; if (M_HRESP !== 2'b11) begin failures++; $display("FAIL split_hresp got=%b exp=11", M_HRESP); end
    tick();
    S1_HRESP = 2'b00; M1_HTRANS = 2'b00; M1_HADDR = ADDR_NONE;
    tick();
    checks++; if (M0_HGRANT !== 1'b1) begin failures++; $display("FAIL split_park got=%b exp=1", M0_HGRANT); end
    tick();
    checks++; if (M1_HGRANT !== 1'b0) begin failures++; $display("FAIL split_masked got=%b exp=0", M1_HGRANT); end
    S1_HSPLIT = 16'h0002;
    tick();
    S1_HSPLIT = 16'h0000;
    #1;
    checks++; if (M1_HGRANT !== 1'b0) begin failures++; $display("FAIL split_clr_lag got=%b exp=0", M1_HGRANT); end
    tick();
    checks++; if (M1_HGRANT !== 1'b1) begin failures++; $display("FAIL split_unmasked got=%b exp=1", M1_HGRANT); end
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_arbitration();
    test_default_slave();
    test_remap();
    test_wait_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
